video_mode_sequencer: RTL and testbench

//  Host-side controller for the arcade video mixer path. Accepts a new video

---
 rtl/video_mode_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_video_mode_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_sequencer.sv
// Video mode sequencer: accepts a host mode, streams the gamma LUT into the mixer
// during VBlank windows, and commits the mode registers at the start of a VBlank.
module video_mode_sequencer #(
    parameter int unsigned GAMMA_ENTRIES = 768
) (
    input  logic       clk_video,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       vblank,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_fx,
    input  logic       cfg_forced_sd,
    input  logic       cfg_gamma_en,
    output logic       rd_req,
    output logic [9:0] rd_addr,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic       gamma_wr,
    output logic [9:0] gamma_addr,
    output logic [7:0] gamma_data,
    output logic       gamma_en,
    output logic [2:0] fx,
    output logic       forced_sd,
    output logic       busy
);

    localparam logic [9:0] LAST_ADDR = 10'(GAMMA_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VBL,
        S_FETCH,
        S_WRITE,
        S_PAUSE,
        S_APPLY_WAIT,
        S_APPLY
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       vbl_q, vbl_d;
    logic       ended_q, ended_d;
    logic [2:0] lat_fx_q, lat_fx_d;
    logic       lat_sd_q, lat_sd_d;
    logic       lat_gen_q, lat_gen_d;
    logic       cfg_ready_q, cfg_ready_d;
    logic       busy_q, busy_d;
    logic       rd_req_q, rd_req_d;
    logic       gamma_wr_q, gamma_wr_d;
    logic       gamma_en_q, gamma_en_d;
    logic [2:0] fx_q, fx_d;
    logic       forced_sd_q, forced_sd_d;

    logic vbl_start;
    logic vbl_end;

    assign vbl_start = ce_pix & vblank & ~vbl_q;
    assign vbl_end   = ce_pix & ~vblank & vbl_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        lat_fx_d    = lat_fx_q;
        lat_sd_d    = lat_sd_q;
        lat_gen_d   = lat_gen_q;
        gamma_en_d  = gamma_en_q;
        fx_d        = fx_q;
        forced_sd_d = forced_sd_q;
        vbl_d       = ce_pix ? vblank : vbl_q;

        // Sticky "VBlank has ended" flag; a fresh VBlank start always clears it.
        if (state_q == S_IDLE)  ended_d = 1'b0;
        else if (vbl_start)     ended_d = 1'b0;
        else if (vbl_end)       ended_d = 1'b1;
        else                    ended_d = ended_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    lat_fx_d  = cfg_fx;
                    lat_sd_d  = cfg_forced_sd;
                    lat_gen_d = cfg_gamma_en;
                    cnt_d     = '0;
                    state_d   = S_WAIT_VBL;
                end
            end
            S_WAIT_VBL: begin
                if (vbl_start) begin
                    if (lat_gen_q) begin
                        gamma_en_d = 1'b0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_FETCH: begin
                if (rd_valid) begin
                    data_d  = rd_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_APPLY_WAIT;
                end else begin
                    cnt_d   = cnt_q + 10'd1;
                    state_d = ended_d ? S_PAUSE : S_FETCH;
                end
            end
            S_PAUSE: begin
                if (vbl_start) state_d = S_FETCH;
            end
            S_APPLY_WAIT: begin
                if (vbl_start || (vbl_q && !ended_d)) state_d = S_APPLY;
            end
            S_APPLY: begin
                fx_d        = lat_fx_q;
                forced_sd_d = lat_sd_q;
                gamma_en_d  = lat_gen_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Status strobes are decoded from the next state so they are registered.
        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rd_req_d    = (state_d == S_FETCH);
        gamma_wr_d  = (state_d == S_WRITE);
    end

    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            vbl_q       <= 1'b0;
            ended_q     <= 1'b0;
            lat_fx_q    <= '0;
            lat_sd_q    <= 1'b0;
            lat_gen_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            gamma_wr_q  <= 1'b0;
            gamma_en_q  <= 1'b0;
            fx_q        <= '0;
            forced_sd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            vbl_q       <= vbl_d;
            ended_q     <= ended_d;
            lat_fx_q    <= lat_fx_d;
            lat_sd_q    <= lat_sd_d;
            lat_gen_q   <= lat_gen_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            rd_req_q    <= rd_req_d;
            gamma_wr_q  <= gamma_wr_d;
            gamma_en_q  <= gamma_en_d;
            fx_q        <= fx_d;
            forced_sd_q <= forced_sd_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign busy       = busy_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = cnt_q;
    assign gamma_wr   = gamma_wr_q;
    assign gamma_addr = cnt_q;
    assign gamma_data = data_q;
    assign gamma_en   = gamma_en_q;
    assign fx         = fx_q;
    assign forced_sd  = forced_sd_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: table-driven mode commits plus
// directed multi-frame gamma LUT load sequences.
module tb_video_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       vblank;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_fx;
    logic       cfg_forced_sd;
    logic       cfg_gamma_en;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       gamma_wr;
    logic [9:0] gamma_addr;
    logic [7:0] gamma_data;
    logic       gamma_en;
    logic [2:0] fx;
    logic       forced_sd;
    logic       busy;

    always #5 clk = ~clk;

    video_mode_sequencer #(.GAMMA_ENTRIES(768)) dut (
        .clk_video     (clk),
        .reset         (reset),
        .ce_pix        (ce_pix),
        .vblank        (vblank),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_fx        (cfg_fx),
        .cfg_forced_sd (cfg_forced_sd),
        .cfg_gamma_en  (cfg_gamma_en),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .gamma_wr      (gamma_wr),
        .gamma_addr    (gamma_addr),
        .gamma_data    (gamma_data),
        .gamma_en      (gamma_en),
        .fx            (fx),
        .forced_sd     (forced_sd),
        .busy          (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // External LUT contents
    function automatic logic [7:0] lut(input logic [9:0] a);
        logic [9:0] t;
        t = a * 10'd37 + 10'd11;
        return t[7:0] ^ {6'b0, a[9:8]};
    endfunction

    // Read responder: rd_valid arrives 3 cycles after rd_req rises
    int unsigned rd_lat = 3;
    logic        stray  = 1'b0;
    logic [9:0]  resp_addr;

    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (stray) begin
                rd_valid = 1'b1;
                rd_data  = 8'hEE;
                @(negedge clk);
                rd_valid = 1'b0;
                stray    = 1'b0;
            end else if (rd_req === 1'b1 && reset === 1'b0) begin
                resp_addr = rd_addr;
                repeat (rd_lat - 1) @(negedge clk);
                rd_valid = 1'b1;
                rd_data  = lut(resp_addr);
                @(negedge clk);
                rd_valid = 1'b0;
            end
        end
    end

    // Write monitor
    int unsigned nwr = 0, exp_next = 0, order_err = 0, data_err = 0, en_err = 0, stab_err = 0;
    logic        prev_req = 1'b0;
    logic [9:0]  prev_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (gamma_wr === 1'b1) begin
                nwr++;
                if (gamma_addr !== 10'(exp_next)) order_err++;
                exp_next = 32'(gamma_addr) + 1;
                if (gamma_data !== lut(gamma_addr)) data_err++;
                if (gamma_en !== 1'b0) en_err++;
            end
            if (rd_req === 1'b1 && prev_req === 1'b1 && rd_addr !== prev_addr) stab_err++;
            prev_req  = rd_req;
            prev_addr = rd_addr;
        end
    end

    task automatic clr_mon();
        nwr = 0; exp_next = 0; order_err = 0; data_err = 0; en_err = 0; stab_err = 0;
    endtask

    task automatic send_cfg(input logic [2:0] f, input logic s, input logic g);
        bit ok;
        ok = 1'b0;
        cfg_fx = f; cfg_forced_sd = s; cfg_gamma_en = g; cfg_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (cfg_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_accept", 32'(ok), 1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        check(nm, 32'(ok), 1);
    endtask

    task automatic wait_fetch(input string nm, input logic [9:0] a, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rd_req === 1'b1 && rd_addr === a) begin ok = 1'b1; break; end
        end
        check(nm, 32'(ok), 1);
    endtask

    typedef struct {
        logic [2:0] fx;
        logic       sd;
        logic       ce;
        logic [2:0] exp_fx;
        logic       exp_sd;
        logic       exp_busy;
    } vec_t;

    vec_t vt[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // A VBlank pulse seen only while ce_pix=0 must not commit anything
        vt[0] = '{3'd2, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        vt[1] = '{3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
        vt[2] = '{3'd7, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1};
        vt[3] = '{3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        vt[4] = '{3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};

        reset = 1'b1; ce_pix = 1'b1; vblank = 1'b0; cfg_valid = 1'b0;
        cfg_fx = '0; cfg_forced_sd = 1'b0; cfg_gamma_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_ctrl", {27'b0, rd_req, gamma_wr, gamma_en, forced_sd, busy}, 0);
        check("rst_data", {1'b0, fx, rd_addr, gamma_addr, gamma_data}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Mode-only commits (gamma disabled)
        for (int i = 0; i < 5; i++) begin
            send_cfg(vt[i].fx, vt[i].sd, 1'b0);
            check("t1_busy_wait", 32'(busy), 1);
            ce_pix = vt[i].ce; vblank = 1'b1;
            @(negedge clk);
            vblank = 1'b0;
            @(negedge clk);
            check("t1_fx", 32'(fx), 32'(vt[i].exp_fx));
            check("t1_sd", 32'(forced_sd), 32'(vt[i].exp_sd));
            check("t1_busy", 32'(busy), 32'(vt[i].exp_busy));
            check("t1_gamma_en", 32'(gamma_en), 0);
            ce_pix = 1'b1;
            if (vt[i].exp_busy) begin
                vblank = 1'b1;
                @(negedge clk);
                vblank = 1'b0;
                @(negedge clk);
                check("t1_late_commit", 32'(fx), 32'(vt[i].fx));
            end
        end
        check("t1_no_writes", nwr, 0);

        // Accepted mid-VBlank: must wait for the next VBlank start
        vblank = 1'b1;
        @(negedge clk);
        send_cfg(3'd6, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("midvbl_no_commit", 32'(fx), 3);
        check("midvbl_busy", 32'(busy), 1);
        vblank = 1'b0;
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midvbl_commit_next", 32'(fx), 6);
        vblank = 1'b0;
        @(negedge clk);

        // cfg_valid pulsed while busy is ignored
        send_cfg(3'd1, 1'b0, 1'b0);
        cfg_fx = 3'd4; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
        check("t4_pulse_ignored", 32'(fx), 1);
        repeat (3) @(negedge clk);
        check("t4_stays_idle", 32'(busy), 0);
        cfg_fx = 3'd4; cfg_valid = 1'b1;
        @(negedge clk);
        check("t4_ready_drop", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
        check("t4_fx_commit", 32'(fx), 4);
        check("t4_ready_back", 32'(cfg_ready), 1);

        // Full LUT load inside one long VBlank
        clr_mon();
        send_cfg(3'd5, 1'b1, 1'b1);
        vblank = 1'b1;
        wait_idle("t2_load_done", 6000);
        check("t2_nwr", nwr, 768);
        check("t2_order", order_err, 0);
        check("t2_data", data_err, 0);
        check("t2_en_during_load", en_err, 0);
        check("t2_addr_stable", stab_err, 0);
        check("t2_gamma_en", 32'(gamma_en), 1);
        check("t2_fx", 32'(fx), 5);
        check("t2_sd", 32'(forced_sd), 1);

        // VBlank ends at entry 300; load resumes next frame
        vblank = 1'b0;
        @(negedge clk);
        clr_mon();
        send_cfg(3'd6, 1'b0, 1'b1);
        vblank = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_bypass", 32'(gamma_en), 0);
        wait_fetch("t3_reach_300", 10'd300, 3000);
        vblank = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_paused_req", 32'(rd_req), 0);
        check("t3_paused_busy", 32'(busy), 1);
        check("t3_writes_at_pause", nwr, 301);
        stray = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_stray_ignored", nwr, 301);
        vblank = 1'b1;
        wait_fetch("t3_resume_301", 10'd301, 10);
        wait_idle("t3_load_done", 6000);
        check("t3_nwr", nwr, 768);
        check("t3_order", order_err, 0);
        check("t3_data", data_err, 0);
        check("t3_fx", 32'(fx), 6);
        check("t3_gamma_en", 32'(gamma_en), 1);

        // Load finishes after VBlank ended: commit waits for the next start
        vblank = 1'b0;
        @(negedge clk);
        clr_mon();
        send_cfg(3'd2, 1'b1, 1'b1);
        vblank = 1'b1;
        wait_fetch("t6_reach_767", 10'd767, 4000);
        vblank = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_waiting", 32'(busy), 1);
        check("t6_fx_held", 32'(fx), 6);
        check("t6_sd_held", 32'(forced_sd), 0);
        check("t6_nwr", nwr, 768);
        vblank = 1'b1;
        @(negedge clk);
        check("t6_not_yet", 32'(fx), 6);
        @(negedge clk);
        check("t6_fx", 32'(fx), 2);
        check("t6_sd", 32'(forced_sd), 1);
        check("t6_gamma_en", 32'(gamma_en), 1);
        check("t6_idle", 32'(busy), 0);

        // Reset in the middle of a load
        vblank = 1'b0;
        @(negedge clk);
        clr_mon();
        send_cfg(3'd5, 1'b1, 1'b1);
        vblank = 1'b1;
        wait_fetch("t5_reach_100", 10'd100, 1000);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_ctrl", {27'b0, rd_req, gamma_wr, gamma_en, forced_sd, busy}, 0);
        check("t5_rst_fx", 32'(fx), 0);
        check("t5_rst_addr", 32'(rd_addr), 0);
        check("t5_rst_ready", 32'(cfg_ready), 1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clr_mon();
        vblank = 1'b0;
        send_cfg(3'd3, 1'b0, 1'b1);
        vblank = 1'b1;
        wait_fetch("t5_restart_addr0", 10'd0, 10);
        repeat (20) @(negedge clk);
        check("t5_restart_writes", 32'(nwr >= 3), 1);
        check("t5_restart_order", order_err, 0);
        check("t5_restart_data", data_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
